ext_pipe_unit: RTL and testbench

- Parametrised successor to the single-cycle immediate extender.
- Handles immediate extension (zero, sign, upper) for ID/EX.
- Handles load-data extension (lb/lbu/lh/lhu) for MEM/WB.
- All results pass through a DEPTH-entry elastic buffer with valid/ready handshake, so a stalled consumer does not drop operations.

---
 rtl/ext_pipe_unit.sv | 88 ++++++++
 tb/tb_ext_pipe_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: immediate/load-data extender feeding a DEPTH-entry valid/ready buffer.
// Define EXT_MISALIGN_EN to store a misaligned-halfword flag alongside each entry.
module ext_pipe_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 2,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [LANE_W-1:0] in_lane,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push, pop;
    logic [LANE_W-1:0] hlane;
    logic [7:0]        byte_v;
    logic [15:0]       half_v, imm;
    logic [DATA_W-1:0] ext;

    always_comb begin
        hlane  = {in_lane[LANE_W-1:1], 1'b0};
        byte_v = in_data[8*in_lane +: 8];
        half_v = in_data[8*hlane +: 16];
        imm    = in_data[15:0];
        case (in_mode)
            3'd0:    ext = {{(DATA_W-16){1'b0}}, imm};
            3'd1:    ext = {{(DATA_W-16){imm[15]}}, imm};
            3'd2:    ext = DATA_W'({imm, 16'h0000});
            3'd3:    ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
            3'd4:    ext = {{(DATA_W-8){1'b0}}, byte_v};
            3'd5:    ext = {{(DATA_W-16){half_v[15]}}, half_v};
            3'd6:    ext = {{(DATA_W-16){1'b0}}, half_v};
            default: ext = in_data;
        endcase
    end

    // in_ready looks only at the registered count so it never depends on out_ready
    assign in_ready  = cnt_q < CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_q] : '0;

    always_comb begin
        wr_d  = flush ? '0 : push ? wr_q + PW'(1) : wr_q;
        rd_d  = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= ext;

`ifdef EXT_MISALIGN_EN
    logic mis_q [DEPTH];

    always_ff @(posedge clk)
        if (push) mis_q[wr_q] <= (in_mode == 3'd5 || in_mode == 3'd6) && in_lane[0];

    assign out_misalign = out_valid && mis_q[rd_q];
`else
    assign out_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb_ext_pipe_unit: directed and random stimulus against a queue-based reference of ext_pipe_unit.
module tb_ext_pipe_unit;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = '0;
    logic [1:0]  in_lane = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_misalign;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_mis;

    always #5 clk = ~clk;

    ext_pipe_unit #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_lane(in_lane), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_misalign(out_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t model(input logic [2:0] m, input logic [1:0] l, input logic [31:0] d);
        ent_t e;
        int unsigned b, h, lo;
        b  = (d >> (8 * l)) & 32'hFF;
        h  = (d >> (16 * (l / 2))) & 32'hFFFF;
        lo = d & 32'hFFFF;
        case (m)
            0: e.data = lo;
            1: e.data = lo >= 32768 ? lo | 32'hFFFF_0000 : lo;
            2: e.data = lo * 65536;
            3: e.data = b >= 128 ? b | 32'hFFFF_FF00 : b;
            4: e.data = b;
            5: e.data = h >= 32768 ? h | 32'hFFFF_0000 : h;
            6: e.data = h;
            default: e.data = d;
        endcase
`ifdef EXT_MISALIGN_EN
        e.mis = (m == 5 || m == 6) && (l % 2 == 1);
`else
        e.mis = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_outs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
        chk("out_data", out_data, q.size() != 0 ? q[0].data : 32'h0);
        chk("out_misalign", {31'b0, out_misalign}, {31'b0, q.size() != 0 ? q[0].mis : 1'b0});
    endtask

    // Called at a negedge: check head state, drive one cycle, update the model at the posedge.
    task automatic cyc(input logic v, input logic [2:0] m, input logic [1:0] l,
                       input logic [31:0] d, input logic ordy, input logic fl);
        logic do_push, do_pop;
        ent_t e;
        in_valid = v; in_mode = m; in_lane = l; in_data = d; out_ready = ordy; flush = fl;
        check_outs();
        do_push = v && q.size() < DEPTH;
        do_pop  = q.size() != 0 && ordy;
        e = model(m, l, d);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
`ifdef EXT_MISALIGN_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_data", out_data, 32'h0);
        chk("rst_mis", {31'b0, out_misalign}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        cyc(1, 1, 0, 32'h0000_8001, 1, 0);
        chk("sext", out_data, 32'hFFFF_8001);
        cyc(1, 0, 0, 32'h0000_8001, 1, 0);
        chk("zext", out_data, 32'h0000_8001);
        cyc(1, 2, 0, 32'h0000_1234, 1, 0);
        chk("lui", out_data, 32'h1234_0000);
        cyc(1, 3, 3, 32'h80FF_7F01, 1, 0);
        chk("lb", out_data, 32'hFFFF_FF80);
        cyc(1, 4, 3, 32'h80FF_7F01, 1, 0);
        chk("lbu", out_data, 32'h0000_0080);
        cyc(1, 5, 2, 32'h8001_0002, 1, 0);
        chk("lh", out_data, 32'hFFFF_8001);
        chk("lh_mis", {31'b0, out_misalign}, 32'h0);
        cyc(1, 5, 3, 32'h8001_0002, 1, 0);
        chk("lh_odd", out_data, 32'hFFFF_8001);
        chk("lh_odd_mis", {31'b0, out_misalign}, {31'b0, exp_mis});
        cyc(0, 0, 0, 0, 1, 0);

        // backpressure: third entry must wait for space
        cyc(1, 7, 0, 32'hA, 0, 0);
        cyc(1, 7, 0, 32'hB, 0, 0);
        chk("full_ready", {31'b0, in_ready}, 32'h0);
        cyc(1, 7, 0, 32'hC, 0, 0);
        cyc(1, 7, 0, 32'hC, 1, 0);
        chk("ready_after_pop", {31'b0, in_ready}, 32'h1);
        chk("second_head", out_data, 32'hB);
        cyc(1, 7, 0, 32'hC, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 1; i <= 8; i++) begin
            cyc(1, 7, 0, i, 1, 0);
            chk("stream", out_data, i);
        end
        cyc(0, 0, 0, 0, 1, 0);

        cyc(1, 7, 0, 32'h11, 0, 0);
        cyc(1, 7, 0, 32'h22, 0, 0);
        cyc(1, 7, 0, 32'h33, 0, 1);
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        chk("flush_ready", {31'b0, in_ready}, 32'h1);
        cyc(1, 7, 0, 32'h44, 0, 0);
        cyc(1, 7, 0, 32'h55, 0, 1);
        chk("flush_drop", {31'b0, out_valid}, 32'h0);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

        cyc(1, 1, 0, 32'h8000, 0, 0);
        cyc(1, 7, 0, 32'hDEAD_BEEF, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_ready", {31'b0, in_ready}, 32'h1);
        chk("arst_data", out_data, 32'h0);
        chk("arst_mis", {31'b0, out_misalign}, 32'h0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 4, 1, 32'h0000_FE00, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check_outs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
